// File: rtl/aes_inv_controller.sv
// aes_inv_controller: sequencer for the AES inverse cipher: key expansion into RAM, initial AddRoundKey, inverse rounds.
// Define AES_INV_KEY_CACHE_EN to add key_reuse, which skips expansion while the stored schedule is valid.
module aes_inv_controller #(
    parameter int  ROUNDS      = 10,
    parameter int  ROUND_DELAY = 7,
    parameter int  KEY_DELAY   = 4,
    localparam int CW          = $clog2(ROUNDS) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
`ifdef AES_INV_KEY_CACHE_EN
    input  logic          key_reuse,
`endif
    output logic          key_sel,
    output logic          key_exp_en,
    output logic          key_wr_en,
    output logic [CW-1:0] key_wr_addr,
    output logic [CW-1:0] key_rd_addr,
    output logic          load,
    output logic          inv_round_en,
    output logic          final_round_sel,
    output logic [CW-1:0] round,
    output logic          busy,
    output logic          done
);
    localparam int TW = $clog2(ROUND_DELAY + KEY_DELAY + 1);

    typedef enum logic [2:0] {IDLE, KEY_EXPAND, INIT_ADD, INV_ROUND, FINAL_ROUND} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d, round_end;
    logic [CW-1:0] k_q, k_d, key_wr_addr_q, key_wr_addr_d, key_rd_addr_q, key_rd_addr_d, round_q, round_d;
    logic          key_sel_q, key_sel_d, key_exp_en_q, key_exp_en_d, key_wr_en_q, key_wr_en_d;
    logic          load_q, load_d, inv_round_en_q, inv_round_en_d, final_round_sel_q, final_round_sel_d;
    logic          busy_q, busy_d, done_q, done_d, reuse_hit;

`ifdef AES_INV_KEY_CACHE_EN
    logic key_valid_q, key_valid_d;

    always_comb key_valid_d = abort ? (key_valid_q && state_q != KEY_EXPAND)
                                    : (key_valid_q || (state_q == KEY_EXPAND && state_d == INIT_ADD));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) key_valid_q <= 1'b0;
        else        key_valid_q <= key_valid_d;

    assign reuse_hit = key_reuse && key_valid_q;
`else
    assign reuse_hit = 1'b0;
`endif

    // The first inverse round also covers the cycle in which the datapath captures the load.
    assign round_end = (round_q == CW'(ROUNDS - 1)) ? TW'(ROUND_DELAY) : TW'(ROUND_DELAY - 1);

    always_comb begin
        state_d           = state_q;
        tmr_d             = tmr_q;
        k_d               = k_q;
        key_sel_d         = key_sel_q;
        key_exp_en_d      = 1'b0;
        key_wr_en_d       = 1'b0;
        key_wr_addr_d     = key_wr_addr_q;
        key_rd_addr_d     = key_rd_addr_q;
        load_d            = 1'b0;
        inv_round_en_d    = 1'b0;
        final_round_sel_d = final_round_sel_q;
        round_d           = round_q;
        busy_d            = busy_q;
        done_d            = 1'b0;
        if (abort) begin
            state_d           = IDLE;
            tmr_d             = '0;
            k_d               = '0;
            key_sel_d         = 1'b0;
            key_wr_addr_d     = '0;
            key_rd_addr_d     = '0;
            final_round_sel_d = 1'b0;
            round_d           = '0;
            busy_d            = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    tmr_d  = '0;
                    busy_d = 1'b1;
                    if (reuse_hit) begin
                        state_d       = INIT_ADD;
                        key_rd_addr_d = CW'(ROUNDS);
                    end else begin
                        state_d       = KEY_EXPAND;
                        key_sel_d     = 1'b1;
                        key_wr_en_d   = 1'b1;
                        key_wr_addr_d = '0;
                        k_d           = CW'(1);
                    end
                end
                KEY_EXPAND: if (tmr_q == TW'(KEY_DELAY - 1)) begin
                    tmr_d         = '0;
                    key_exp_en_d  = 1'b1;
                    key_wr_en_d   = 1'b1;
                    key_wr_addr_d = k_q;
                    key_sel_d     = 1'b0;
                    k_d           = k_q + 1'b1;
                    if (k_q == CW'(ROUNDS)) begin
                        state_d       = INIT_ADD;
                        key_rd_addr_d = CW'(ROUNDS);
                    end
                end else tmr_d = tmr_q + 1'b1;
                INIT_ADD: begin
                    state_d       = INV_ROUND;
                    tmr_d         = '0;
                    load_d        = 1'b1;
                    round_d       = CW'(ROUNDS - 1);
                    key_rd_addr_d = CW'(ROUNDS - 1);
                end
                INV_ROUND: if (tmr_q == round_end) begin
                    tmr_d          = '0;
                    inv_round_en_d = 1'b1;
                    round_d        = round_q - 1'b1;
                    key_rd_addr_d  = round_q - 1'b1;
                    if (round_q == CW'(1)) begin
                        state_d           = FINAL_ROUND;
                        final_round_sel_d = 1'b1;
                    end
                end else tmr_d = tmr_q + 1'b1;
                FINAL_ROUND: if (tmr_q == TW'(ROUND_DELAY - 1)) begin
                    state_d           = IDLE;
                    tmr_d             = '0;
                    inv_round_en_d    = 1'b1;
                    done_d            = 1'b1;
                    final_round_sel_d = 1'b0;
                    round_d           = '0;
                    busy_d            = 1'b0;
                end else tmr_d = tmr_q + 1'b1;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            tmr_q             <= '0;
            k_q               <= '0;
            key_sel_q         <= 1'b0;
            key_exp_en_q      <= 1'b0;
            key_wr_en_q       <= 1'b0;
            key_wr_addr_q     <= '0;
            key_rd_addr_q     <= '0;
            load_q            <= 1'b0;
            inv_round_en_q    <= 1'b0;
            final_round_sel_q <= 1'b0;
            round_q           <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            tmr_q             <= tmr_d;
            k_q               <= k_d;
            key_sel_q         <= key_sel_d;
            key_exp_en_q      <= key_exp_en_d;
            key_wr_en_q       <= key_wr_en_d;
            key_wr_addr_q     <= key_wr_addr_d;
            key_rd_addr_q     <= key_rd_addr_d;
            load_q            <= load_d;
            inv_round_en_q    <= inv_round_en_d;
            final_round_sel_q <= final_round_sel_d;
            round_q           <= round_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
        end
    end

    assign key_sel         = key_sel_q;
    assign key_exp_en      = key_exp_en_q;
    assign key_wr_en       = key_wr_en_q;
    assign key_wr_addr     = key_wr_addr_q;
    assign key_rd_addr     = key_rd_addr_q;
    assign load            = load_q;
    assign inv_round_en    = inv_round_en_q;
    assign final_round_sel = final_round_sel_q;
    assign round           = round_q;
    assign busy            = busy_q;
    assign done            = done_q;
endmodule

// File: tb/tb_aes_inv_controller.sv
// tb_aes_inv_controller: table-driven and scoreboard checks of aes_inv_controller, default and ROUNDS=14 builds.
module tb_aes_inv_controller;
    localparam int R  = 10;
    localparam int CW = 5;

    typedef struct { int cyc; int nexp; int nwr; } op_t;
    typedef struct { int off; logic [22:0] exp; } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, start14 = 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
    logic key_reuse = 1'b0;
`endif
    logic          key_sel, key_exp_en, key_wr_en, load, inv_round_en, final_round_sel, busy, done;
    logic [CW-1:0] key_wr_addr, key_rd_addr, round;
    logic          s14_sel, s14_exp, s14_wr, s14_ld, s14_inv, s14_fin, s14_busy, s14_done;
    logic [4:0]    s14_wa, s14_ra, s14_rnd;
    logic [22:0]   outs;

    int   cyc = 0, checks = 0, failures = 0;
    int   n_exp = 0, n_wr = 0, n_ld = 0, n_inv = 0;
    op_t  exp_q[$];
    vec_t tbl[13];

    aes_inv_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef AES_INV_KEY_CACHE_EN
        .key_reuse(key_reuse),
`endif
        .key_sel(key_sel), .key_exp_en(key_exp_en), .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr),
        .key_rd_addr(key_rd_addr), .load(load), .inv_round_en(inv_round_en),
        .final_round_sel(final_round_sel), .round(round), .busy(busy), .done(done));

    aes_inv_controller #(.ROUNDS(14), .ROUND_DELAY(5), .KEY_DELAY(2)) dut14 (
        .clk(clk), .rst_n(rst_n), .start(start14), .abort(1'b0),
`ifdef AES_INV_KEY_CACHE_EN
        .key_reuse(1'b0),
`endif
        .key_sel(s14_sel), .key_exp_en(s14_exp), .key_wr_en(s14_wr), .key_wr_addr(s14_wa),
        .key_rd_addr(s14_ra), .load(s14_ld), .inv_round_en(s14_inv),
        .final_round_sel(s14_fin), .round(s14_rnd), .busy(s14_busy), .done(s14_done));

    assign outs = {key_sel, key_exp_en, key_wr_en, key_wr_addr, key_rd_addr, load, inv_round_en,
                   final_round_sel, round, busy, done};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [22:0] pk(input logic ks, ke, kw, input int wa, ra,
                                       input logic ld, ir, fs, input int rd, input logic bz, dn);
        return {ks, ke, kw, 5'(wa), 5'(ra), ld, ir, fs, 5'(rd), bz, dn};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Scoreboard: each accepted start pushes its expected done cycle and strobe counts.
    always @(posedge clk) begin : mon
        op_t e;
        if (abort || !rst_n) begin
            exp_q.delete();
            n_exp = 0; n_wr = 0; n_ld = 0; n_inv = 0;
        end
        #1;
        n_exp += int'(key_exp_en);
        n_wr  += int'(key_wr_en);
        n_ld  += int'(load);
        n_inv += int'(inv_round_en);
        if (done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 64'(cyc), '1);
            else begin
                e = exp_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("key_exp_count", 64'(n_exp), 64'(e.nexp));
                chk("key_wr_count", 64'(n_wr), 64'(e.nwr));
                chk("load_count", 64'(n_ld), 64'd1);
                chk("inv_round_count", 64'(n_inv), 64'(R));
            end
            n_exp = 0; n_wr = 0; n_ld = 0; n_inv = 0;
        end
    end

    task automatic push_op(input int c, input int nexp, input int nwr);
        op_t e;
        e.cyc = c; e.nexp = nexp; e.nwr = nwr;
        exp_q.push_back(e);
    endtask

    task automatic launch(input int nexp, input int nwr, input int lat, output int c0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; c0 = cyc;
        push_op(c0 + lat, nexp, nwr);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int c0, mask, n14_exp, n14_inv, first_rnd, dlat;
        tbl[0]  = '{0,   pk(1, 0, 1, 0,  0,  0, 0, 0, 0, 1, 0)};
        tbl[1]  = '{1,   pk(1, 0, 0, 0,  0,  0, 0, 0, 0, 1, 0)};
        tbl[2]  = '{4,   pk(0, 1, 1, 1,  0,  0, 0, 0, 0, 1, 0)};
        tbl[3]  = '{5,   pk(0, 0, 0, 1,  0,  0, 0, 0, 0, 1, 0)};
        tbl[4]  = '{40,  pk(0, 1, 1, 10, 10, 0, 0, 0, 0, 1, 0)};
        tbl[5]  = '{41,  pk(0, 0, 0, 10, 9,  1, 0, 0, 9, 1, 0)};
        tbl[6]  = '{48,  pk(0, 0, 0, 10, 9,  0, 0, 0, 9, 1, 0)};
        tbl[7]  = '{49,  pk(0, 0, 0, 10, 8,  0, 1, 0, 8, 1, 0)};
        tbl[8]  = '{56,  pk(0, 0, 0, 10, 7,  0, 1, 0, 7, 1, 0)};
        tbl[9]  = '{105, pk(0, 0, 0, 10, 0,  0, 1, 1, 0, 1, 0)};
        tbl[10] = '{111, pk(0, 0, 0, 10, 0,  0, 0, 1, 0, 1, 0)};
        tbl[11] = '{112, pk(0, 0, 0, 10, 0,  0, 1, 0, 0, 0, 1)};
        tbl[12] = '{113, pk(0, 0, 0, 10, 0,  0, 0, 0, 0, 0, 0)};

        repeat (3) @(negedge clk);
        chk("reset_outs", 64'(outs), 64'd0);
        chk("reset_busy14", 64'(s14_busy), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        launch(R, R + 1, 112, c0);
        foreach (tbl[i]) begin
            while (cyc < c0 + tbl[i].off) @(negedge clk);
            chk($sformatf("table_off%0d", tbl[i].off), 64'(outs), 64'(tbl[i].exp));
        end
        drain("table_pending", 20);

        @(negedge clk); start = 1'b1;
        @(negedge clk); c0 = cyc;
        push_op(c0 + 112, R, R + 1);
        push_op(c0 + 225, R, R + 1);
        while (cyc < c0 + 112) @(negedge clk);
        chk("held_done_cycle_idle", 64'(busy), 64'd0);
        @(negedge clk);
        chk("held_restart", 64'({busy, key_sel, key_wr_en}), 64'b111);
        start = 1'b0;
        drain("held_pending", 200);

        launch(R, R + 1, 112, c0);
        while (cyc < c0 + 59) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_outs", 64'(outs), 64'd0);
        repeat (80) @(negedge clk);
        launch(R, R + 1, 112, c0);
        drain("after_abort_pending", 150);

        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("abort_beats_start", 64'(busy), 64'd0);

        launch(R, R + 1, 112, c0);
        while (cyc < c0 + 10) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", 64'(outs), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (120) @(negedge clk);

        mask = 0; n14_exp = 0; n14_inv = 0; first_rnd = -1; dlat = -1;
        @(negedge clk); start14 = 1'b1;
        @(negedge clk); start14 = 1'b0; c0 = cyc;
        for (int i = 0; i < 200 && dlat < 0; i++) begin
            if (s14_wr) mask |= 1 << s14_wa;
            if (s14_exp) n14_exp++;
            if (s14_inv) n14_inv++;
            if (s14_ld) first_rnd = int'(s14_rnd);
            if (s14_done) dlat = cyc - c0;
            @(negedge clk);
        end
        chk("r14_wr_mask", 64'(mask), 64'h7fff);
        chk("r14_key_exp_count", 64'(n14_exp), 64'd14);
        chk("r14_inv_count", 64'(n14_inv), 64'd14);
        chk("r14_first_round", 64'(first_rnd), 64'd13);
        chk("r14_done_latency", 64'(dlat), 64'd100);

`ifdef AES_INV_KEY_CACHE_EN
        key_reuse = 1'b1;
        launch(R, R + 1, 112, c0);
        drain("cache_cold_pending", 150);
        launch(0, 0, 72, c0);
        drain("cache_hit_pending", 100);
        key_reuse = 1'b0;
`endif

        drain("final_pending", 10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_inv_controller.md
Name: aes_inv_controller

Overview:
Sequencing controller for the AES-128 inverse cipher (decryption) datapath, the counterpart of the encryption controller. On start it first runs the forward key schedule once, writing round keys 0..ROUNDS into an external round-key RAM. It then issues the initial AddRoundKey with key ROUNDS, followed by inverse rounds that read keys in descending order down to 0. All outputs are registered and drive the inverse datapath, the key-schedule unit and the key RAM.

Parameters:
ROUNDS, 10, number of cipher rounds; CW = $clog2(ROUNDS)+1 is the counter/address width.
ROUND_DELAY, 7, cycles per inverse round (datapath pipeline depth).
KEY_DELAY, 4, cycles per key-expansion step.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  begin a decryption; sampled only in IDLE.
abort  in  1  synchronous cancel; highest priority after reset.
key_sel  out  1  1 = key schedule loads the external cipher key; 0 = it feeds back.
key_exp_en  out  1  one-cycle strobe: advance the key schedule one step.
key_wr_en  out  1  one-cycle strobe: write the current schedule output to the key RAM.
key_wr_addr  out  CW  key RAM write index.
key_rd_addr  out  CW  key RAM read index; held stable for a whole round.
load  out  1  one-cycle strobe: state <= ciphertext XOR rk[ROUNDS].
inv_round_en  out  1  one-cycle strobe: state register captures the inverse-round result.
final_round_sel  out  1  1 during the last round (InvMixColumns bypassed).
round  out  CW  current round index (descending).
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the plaintext is valid.

Behaviour:
- Reset values: all outputs 0; state IDLE; all timers 0. Reset mid-operation aborts immediately, and no done is issued.
- Registered outputs: each strobe is computed combinationally and is visible one cycle after the edge that decided it.
- IDLE, start=1:
  - next state KEY_EXPAND; key_sel=1.
  - key_wr_en=1 with key_wr_addr=0 (the raw key becomes rk0).
  - step counter k=1; busy=1.
- KEY_EXPAND:
  - timer counts 0..KEY_DELAY-1. At KEY_DELAY-1: key_exp_en=1, key_wr_en=1, key_wr_addr=k, key_sel=0, k++, timer=0.
  - After k==ROUNDS is written: next state INIT_ADD; key_rd_addr=ROUNDS.
- INIT_ADD (1 cycle): load=1; round=ROUNDS-1; key_rd_addr=ROUNDS-1; next state INV_ROUND.
- INV_ROUND:
  - timer counts 0..ROUND_DELAY-1. At ROUND_DELAY-1: inv_round_en=1, timer=0, round--, key_rd_addr=round-1.
  - If the round just completed was 1: next state FINAL_ROUND; final_round_sel=1; round=0; key_rd_addr=0.
- FINAL_ROUND: at timer ROUND_DELAY-1: inv_round_en=1, done=1, final_round_sel=0, round=0, busy=0; next state IDLE.
- Latency: done is high exactly ROUNDS*(KEY_DELAY+ROUND_DELAY)+2 cycles after the edge that sampled start. Default is 112.
- Strobe counts per operation:
  - key_exp_en: ROUNDS pulses.
  - key_wr_en: ROUNDS+1 pulses.
  - load: 1 pulse.
  - inv_round_en: ROUNDS pulses.
  - done: 1 pulse.
- start while busy: ignored, with no restart.
- In the done cycle the state is already IDLE, so start in that cycle is accepted (back-to-back with zero gap).
- abort in any state: next edge goes to IDLE and all outputs return to reset values. done is not pulsed. abort beats a simultaneous start.
- round and key_rd_addr never wrap: the minimum is 0 and the maximum is ROUNDS.

Optional Feature:
AES_INV_KEY_CACHE_EN
- Defined:
  - Adds input port key_reuse (1 bit) and an internal key_valid flag.
  - key_valid is set when KEY_EXPAND completes and is cleared by reset or by abort during KEY_EXPAND.
  - start with key_reuse=1 and key_valid=1 skips KEY_EXPAND: IDLE goes directly to INIT_ADD, and no key_exp_en or key_wr_en pulses occur.
  - Latency becomes ROUNDS*ROUND_DELAY+2 (default 72).
  - key_reuse=1 with key_valid=0 behaves as a normal full expansion.
- Not defined: there is no key_reuse port, and every start performs full expansion.

Test Plan:
- Reset then a 1-cycle start, default parameters:
  - key_wr_en pulses at addresses 0..10; key_exp_en pulses 10 times.
  - load pulses once; inv_round_en pulses 10 times.
  - round and key_rd_addr step 9..0; final_round_sel is high only in the final round.
  - done pulses exactly 112 cycles after start.
- start held high through the whole operation: exactly one operation runs; the second one begins in the done cycle, and its done arrives 112 cycles later.
- abort asserted at cycle 60 (INV_ROUND): next cycle busy=0 and all outputs are 0; no done occurs; a new start then completes in 112 cycles.
- rst_n driven low asynchronously mid-KEY_EXPAND: outputs go to 0 immediately, without waiting for a clock edge.
- ROUNDS=14, ROUND_DELAY=5, KEY_DELAY=2: key_wr_en pulses at addresses 0..14; round steps 13..0; done arrives at 14*7+2=100 cycles.
- AES_INV_KEY_CACHE_EN defined, with a second start where key_reuse=1: no key_exp_en or key_wr_en pulses; done arrives at 72 cycles. With key_reuse=1 after reset, done arrives at 112 cycles.
